sumador_serie_n: RTL

//  Parametrised multi-cycle adder. Computes S = A + B + Cin over WIDTH/DIGIT clock

---
 rtl/sumador_serie_n.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sumador_serie_n.sv
// rtl/sumador_serie_n.sv - digit-serial adder, valid/ready handshake; define SUMADOR_SERIE_OVF_EN for the ovf output
module sumador_serie_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SUMADOR_SERIE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Reject geometries the digit slicing cannot cover exactly.
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("sumador_serie_n: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [DIGIT:0]   digit_sum;
    logic             last_step;
    logic             accept;

    // One DIGIT-wide slice; the top bit is the carry into the next digit.
    assign digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

    // New digit enters at the MSB end while the partial sum moves right by one digit.
    assign s_next    = WIDTH'({digit_sum[DIGIT-1:0], s_sh} >> DIGIT);
    assign last_step = (cnt == CNT_W'(STEPS - 1));
    assign accept    = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept -> run STEPS digits -> hold result until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    // Operand shift registers, carry and step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= A;
            b_sh  <= B;
            s_sh  <= '0;
            carry <= Cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            s_sh  <= s_next;
            carry <= digit_sum[DIGIT];
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result registers: written only on the final digit so partial sums never show on S.
    always_ff @(posedge clk) begin
        if (rst) begin
            S    <= '0;
            Cout <= 1'b0;
        end else if (state == RUN && last_step) begin
            S    <= s_next;
            Cout <= digit_sum[DIGIT];
        end
    end

`ifdef SUMADOR_SERIE_OVF_EN
    logic carry_msb;

    // In the last digit the MSB operand bits sit at DIGIT-1; a^b^sum recovers the carry into it.
    assign carry_msb = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ digit_sum[DIGIT-1];

    // Two's-complement overflow, captured alongside S and held with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == RUN && last_step) begin
            ovf <= carry_msb ^ digit_sum[DIGIT];
        end
    end
`endif

endmodule
